// File: rtl/icache_pkg.sv
// Shared types and default geometry for the instruction cache.
//   ICACHE_*        default cache geometry
//   icache_state_t  controller state
//   icache_line_t   one cache line (valid, tag, data) at the default geometry
package icache_pkg;

    localparam int unsigned ICACHE_ADDR_LEN   = 32;
    localparam int unsigned ICACHE_INST_LEN   = 32;
    localparam int unsigned ICACHE_LINE_BYTES = 16;
    localparam int unsigned ICACHE_NUM_LINES  = 4;
    localparam int unsigned ICACHE_LINE_BITS  = 8 * ICACHE_LINE_BYTES;
    localparam int unsigned ICACHE_TAG_BITS   =
        ICACHE_ADDR_LEN - $clog2(ICACHE_LINE_BYTES) - $clog2(ICACHE_NUM_LINES);

    typedef enum logic [0:0] {
        IC_IDLE,
        IC_MISS
    } icache_state_t;

    typedef struct packed {
        logic                        valid;
        logic [ICACHE_TAG_BITS-1:0]  tag;
        logic [ICACHE_LINE_BITS-1:0] data;
    } icache_line_t;

endpackage

// File: rtl/icache_line_array.sv
// Storage for the direct-mapped cache lines.
//   clk                      clock
//   clear                    clears every valid bit at the edge (has priority over write)
//   wr_en/wr_idx/wr_tag/wr_data  synchronous line write, sets valid
//   rd_idx                   asynchronous read index
//   rd_valid/rd_tag/rd_data  contents of the addressed line
module icache_line_array #(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned TAG_BITS  = 26,
    parameter int unsigned LINE_BITS = 128,
    localparam int unsigned IDX_BITS = $clog2(NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [LINE_BITS-1:0] wr_data,
    input  logic [IDX_BITS-1:0]  rd_idx,
    output logic                 rd_valid,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [LINE_BITS-1:0] rd_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only ever observed through valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between fetch and main memory.
//   clk, rst                  clock, synchronous active-high reset
//   fet_req_in, fet_pc_in     fetch lookup request and byte address
//   fet_inst_out, fet_valid_out  hit data, valid in the same cycle
//   stall_ic_out              miss or fill in progress; fetch holds its PC
//   flush_in                  invalidate every line
//   mem_req_out, mem_addr_out line-fill request and line-aligned address
//   mem_ready_in, mem_line_in fill handshake and line data (word 0 in low bits)
module icache
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_LEN   = ICACHE_ADDR_LEN,
    parameter int unsigned INST_LEN   = ICACHE_INST_LEN,
    parameter int unsigned LINE_BYTES = ICACHE_LINE_BYTES,
    parameter int unsigned NUM_LINES  = ICACHE_NUM_LINES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fet_req_in,
    input  logic [ADDR_LEN-1:0]     fet_pc_in,
    output logic [INST_LEN-1:0]     fet_inst_out,
    output logic                    fet_valid_out,
    output logic                    stall_ic_out,
    input  logic                    flush_in,
    output logic                    mem_req_out,
    output logic [ADDR_LEN-1:0]     mem_addr_out,
    input  logic                    mem_ready_in,
    input  logic [8*LINE_BYTES-1:0] mem_line_in
);

    localparam int unsigned LINE_BITS = 8 * LINE_BYTES;
    localparam int unsigned OFF       = $clog2(LINE_BYTES);
    localparam int unsigned IDX       = $clog2(NUM_LINES);
    localparam int unsigned TAG       = ADDR_LEN - OFF - IDX;
    localparam int unsigned WSEL_W    = (OFF > 2) ? OFF - 2 : 1;

    icache_state_t       state_q;
    logic                mem_req_q;
    logic [ADDR_LEN-1:0] mem_addr_q;
    logic                kill_q;

    logic [IDX-1:0]       rd_idx;
    logic [TAG-1:0]       pc_tag;
    logic                 rd_valid;
    logic [TAG-1:0]       rd_tag;
    logic [LINE_BITS-1:0] rd_data;
    logic [WSEL_W-1:0]    wsel;
    logic                 hit;
    logic                 lookup;
    logic                 wr_en;
    logic                 unused_pc;

    assign rd_idx    = fet_pc_in[OFF+IDX-1:OFF];
    assign pc_tag    = fet_pc_in[ADDR_LEN-1:OFF+IDX];
    assign unused_pc = ^fet_pc_in[1:0];

    if (OFF > 2) begin : g_wsel
        assign wsel = fet_pc_in[OFF-1:2];
    end else begin : g_wsel_single
        assign wsel = '0;
    end

    assign hit    = rd_valid && (rd_tag == pc_tag);
    assign lookup = !rst && (state_q == IC_IDLE) && fet_req_in;

    assign fet_valid_out = lookup && hit;
    assign fet_inst_out  = fet_valid_out ? rd_data[int'(wsel) * INST_LEN +: INST_LEN] : '0;
    assign stall_ic_out  = !rst && ((lookup && !hit) || (state_q == IC_MISS));
    assign mem_req_out   = mem_req_q;
    assign mem_addr_out  = mem_addr_q;

    // A flush seen at any point of the fill (including the delivery cycle) drops the data.
    assign wr_en = (state_q == IC_MISS) && mem_ready_in && !kill_q && !flush_in;

    icache_line_array #(
        .NUM_LINES (NUM_LINES),
        .TAG_BITS  (TAG),
        .LINE_BITS (LINE_BITS)
    ) u_lines (
        .clk      (clk),
        .clear    (rst || flush_in),
        .wr_en    (wr_en),
        .wr_idx   (mem_addr_q[OFF+IDX-1:OFF]),
        .wr_tag   (mem_addr_q[ADDR_LEN-1:OFF+IDX]),
        .wr_data  (mem_line_in),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IC_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            kill_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IC_IDLE: begin
                    kill_q <= 1'b0;
                    if (fet_req_in && !hit) begin
                        state_q    <= IC_MISS;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {fet_pc_in[ADDR_LEN-1:OFF], {OFF{1'b0}}};
                    end
                end
                IC_MISS: begin
                    if (flush_in) begin
                        kill_q <= 1'b1;
                    end
                    if (mem_ready_in) begin
                        state_q   <= IC_IDLE;
                        mem_req_q <= 1'b0;
                        kill_q    <= 1'b0;
                    end
                end
                default: state_q <= IC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

    localparam logic [127:0] L0 = {32'h33, 32'h22, 32'h11, 32'h00};
    localparam logic [127:0] L1 = {32'h1C, 32'h18, 32'h14, 32'h10};
    localparam logic [127:0] L2 = {32'h2C, 32'h28, 32'h24, 32'h20};
    localparam logic [127:0] L4 = {32'h4C, 32'h48, 32'h44, 32'h40};

    logic         clk;
    logic         rst;
    logic         fet_req_in;
    logic [31:0]  fet_pc_in;
    logic [31:0]  fet_inst_out;
    logic         fet_valid_out;
    logic         stall_ic_out;
    logic         flush_in;
    logic         mem_req_out;
    logic [31:0]  mem_addr_out;
    logic         mem_ready_in;
    logic [127:0] mem_line_in;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit           rst;
        bit           req;
        logic [31:0]  pc;
        bit           flush;
        bit           ready;
        logic [127:0] line;
        bit           exp_valid;
        logic [31:0]  exp_inst;
        bit           exp_stall;
        bit           exp_mreq;
        logic [31:0]  exp_maddr;
    } vec_t;

    vec_t tbl[$];

    icache u_dut (
        .clk           (clk),
        .rst           (rst),
        .fet_req_in    (fet_req_in),
        .fet_pc_in     (fet_pc_in),
        .fet_inst_out  (fet_inst_out),
        .fet_valid_out (fet_valid_out),
        .stall_ic_out  (stall_ic_out),
        .flush_in      (flush_in),
        .mem_req_out   (mem_req_out),
        .mem_addr_out  (mem_addr_out),
        .mem_ready_in  (mem_ready_in),
        .mem_line_in   (mem_line_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(bit r, bit rq, logic [31:0] pc, bit fl, bit rdy,
                               logic [127:0] ln, bit ev, logic [31:0] ei, bit es,
                               bit em, logic [31:0] ea);
        vec_t x;
        x.rst = r;        x.req = rq;       x.pc = pc;
        x.flush = fl;     x.ready = rdy;    x.line = ln;
        x.exp_valid = ev; x.exp_inst = ei;  x.exp_stall = es;
        x.exp_mreq = em;  x.exp_maddr = ea;
        return x;
    endfunction

    task automatic chk(input string nm, input int row, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit rq, input logic [31:0] pc, input bit fl,
                         input bit rdy, input logic [127:0] ln);
        @(negedge clk);
        rst          = r;
        fet_req_in   = rq;
        fet_pc_in    = pc;
        flush_in     = fl;
        mem_ready_in = rdy;
        mem_line_in  = ln;
        #1;
    endtask

    task automatic check_outs(input int row, input bit ev, input logic [31:0] ei,
                              input bit chk_inst, input bit es, input bit em,
                              input logic [31:0] ea);
        chk("fet_valid", row, 128'(fet_valid_out), 128'(ev));
        if (chk_inst) chk("fet_inst", row, 128'(fet_inst_out), 128'(ei));
        chk("stall", row, 128'(stall_ic_out), 128'(es));
        chk("mem_req", row, 128'(mem_req_out), 128'(em));
        chk("mem_addr", row, 128'(mem_addr_out), 128'(ea));
    endtask

    initial begin
        rst = 1'b1; fet_req_in = 1'b0; fet_pc_in = '0; flush_in = 1'b0;
        mem_ready_in = 1'b0; mem_line_in = '0;
        @(posedge clk);

        // Reset state, then cold miss on line 0 with 5 cycles of memory latency.
        tbl.push_back(v(1, 0, 32'h00, 0, 0, 0,  0, 0, 0, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 0, 0, 0,  0, 0, 1, 0, 32'h00));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0, 1, 32'h00, 0, 0, 0,  0, 0, 1, 1, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 0, 1, L0, 0, 0, 1, 1, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 0, 0, 0,  1, 32'h00, 0, 0, 32'h00));
        // Back-to-back hits on the rest of the line; pc[1:0] ignored.
        tbl.push_back(v(0, 1, 32'h04, 0, 0, 0,  1, 32'h11, 0, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h08, 0, 0, 0,  1, 32'h22, 0, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h0C, 0, 0, 0,  1, 32'h33, 0, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h0E, 0, 0, 0,  1, 32'h33, 0, 0, 32'h00));
        tbl.push_back(v(0, 0, 32'h04, 0, 0, 0,  0, 0, 0, 0, 32'h00));
        // Conflict miss at 0x40 evicts line 0x00, which then misses again.
        tbl.push_back(v(0, 1, 32'h40, 0, 0, 0,  0, 0, 1, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h40, 0, 0, 0,  0, 0, 1, 1, 32'h40));
        tbl.push_back(v(0, 1, 32'h40, 0, 1, L4, 0, 0, 1, 1, 32'h40));
        tbl.push_back(v(0, 1, 32'h40, 0, 0, 0,  1, 32'h40, 0, 0, 32'h40));
        tbl.push_back(v(0, 1, 32'h48, 0, 0, 0,  1, 32'h48, 0, 0, 32'h40));
        tbl.push_back(v(0, 1, 32'h00, 0, 0, 0,  0, 0, 1, 0, 32'h40));
        tbl.push_back(v(0, 1, 32'h00, 0, 0, 0,  0, 0, 1, 1, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 0, 1, L0, 0, 0, 1, 1, 32'h00));
        tbl.push_back(v(0, 1, 32'h00, 0, 0, 0,  1, 32'h00, 0, 0, 32'h00));
        // Flush in IDLE: same-cycle lookup still hits, next one misses.
        tbl.push_back(v(0, 1, 32'h08, 1, 0, 0,  1, 32'h22, 0, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h08, 0, 0, 0,  0, 0, 1, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h08, 0, 0, 0,  0, 0, 1, 1, 32'h00));
        // Flush together with ready discards the fill.
        tbl.push_back(v(0, 1, 32'h08, 1, 1, L0, 0, 0, 1, 1, 32'h00));
        tbl.push_back(v(0, 1, 32'h08, 0, 0, 0,  0, 0, 1, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h08, 0, 0, 0,  0, 0, 1, 1, 32'h00));
        // Flush before ready kills the fill that arrives later.
        tbl.push_back(v(0, 1, 32'h08, 1, 0, 0,  0, 0, 1, 1, 32'h00));
        tbl.push_back(v(0, 1, 32'h08, 0, 1, L0, 0, 0, 1, 1, 32'h00));
        tbl.push_back(v(0, 1, 32'h08, 0, 0, 0,  0, 0, 1, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h08, 0, 0, 0,  0, 0, 1, 1, 32'h00));
        tbl.push_back(v(0, 1, 32'h08, 0, 1, L0, 0, 0, 1, 1, 32'h00));
        tbl.push_back(v(0, 1, 32'h08, 0, 0, 0,  1, 32'h22, 0, 0, 32'h00));
        // Second index is independent of line 0.
        tbl.push_back(v(0, 1, 32'h14, 0, 0, 0,  0, 0, 1, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h14, 0, 0, 0,  0, 0, 1, 1, 32'h10));
        tbl.push_back(v(0, 1, 32'h14, 0, 1, L1, 0, 0, 1, 1, 32'h10));
        tbl.push_back(v(0, 1, 32'h14, 0, 0, 0,  1, 32'h14, 0, 0, 32'h10));
        tbl.push_back(v(0, 1, 32'h08, 0, 0, 0,  1, 32'h22, 0, 0, 32'h10));
        // Reset mid-miss; a stray ready afterwards is ignored.
        tbl.push_back(v(0, 1, 32'h40, 0, 0, 0,  0, 0, 1, 0, 32'h10));
        tbl.push_back(v(0, 1, 32'h40, 0, 0, 0,  0, 0, 1, 1, 32'h40));
        tbl.push_back(v(1, 1, 32'h40, 0, 0, 0,  0, 0, 0, 1, 32'h40));
        tbl.push_back(v(0, 0, 32'h40, 0, 1, L4, 0, 0, 0, 0, 32'h00));
        tbl.push_back(v(0, 0, 32'h40, 0, 0, 0,  0, 0, 0, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h40, 0, 0, 0,  0, 0, 1, 0, 32'h00));
        tbl.push_back(v(0, 1, 32'h40, 0, 0, 0,  0, 0, 1, 1, 32'h40));
        tbl.push_back(v(0, 1, 32'h40, 0, 1, L4, 0, 0, 1, 1, 32'h40));
        tbl.push_back(v(0, 1, 32'h40, 0, 0, 0,  1, 32'h40, 0, 0, 32'h40));
        tbl.push_back(v(0, 1, 32'h14, 0, 0, 0,  0, 0, 1, 0, 32'h40));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].pc, tbl[i].flush, tbl[i].ready,
                  tbl[i].line);
            check_outs(i, tbl[i].exp_valid, tbl[i].exp_inst,
                       tbl[i].exp_valid || tbl[i].rst, tbl[i].exp_stall,
                       tbl[i].exp_mreq, tbl[i].exp_maddr);
        end

        // Long memory latency on index 2: request and address must stay stable.
        drive(1, 0, 32'h00, 0, 0, 0);
        drive(0, 1, 32'h2C, 0, 0, 0);
        check_outs(1000, 0, 0, 0, 1, 0, 32'h00);
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 32'h2C, 0, 0, 0);
            check_outs(1001 + i, 0, 0, 0, 1, 1, 32'h20);
        end
        drive(0, 1, 32'h2C, 0, 1, L2);
        check_outs(1013, 0, 0, 0, 1, 1, 32'h20);
        drive(0, 1, 32'h2C, 0, 0, 0);
        check_outs(1014, 1, 32'h2C, 1, 0, 0, 32'h20);
        drive(0, 1, 32'h24, 0, 0, 0);
        check_outs(1015, 1, 32'h24, 1, 0, 0, 32'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
